hazard5_ahbl_arbiter: RTL and testbench

//  N-master to 1-slave AHB-Lite arbiter. Lets several bus masters (e.g. two

---
 rtl/hazard5_ahbl_pkg.sv | 17 +
 rtl/hazard5_rr_priority.sv | 30 +++
 rtl/hazard5_ahbl_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_hazard5_ahbl_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard5_ahbl_pkg.sv
// Shared AHB-Lite encodings and per-port sideband field widths for the
// hazard5 bus fabric.
package hazard5_ahbl_pkg;

  localparam int W_HTRANS = 2;
  localparam int W_HSIZE  = 3;
  localparam int W_HPROT  = 4;
  localparam int W_HBURST = 3;

  localparam logic [W_HTRANS-1:0] HTRANS_IDLE = 2'b00;
  localparam logic [W_HTRANS-1:0] HTRANS_BUSY = 2'b01;
  localparam logic [W_HTRANS-1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [W_HTRANS-1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [W_HBURST-1:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/hazard5_rr_priority.sv
// Round-robin priority select: one-hot grant to the first set request found
// scanning upward from ptr_i, wrapping at N.
module hazard5_rr_priority #(
  parameter  int N     = 2,
  localparam int W_PTR = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [W_PTR-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  int   idx;
  logic found;

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop, so no
    // path through this block can leave a signal unassigned and infer a latch.
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard5_ahbl_arbiter.sv
// N-master to 1-slave AHB-Lite arbiter: round-robin grant, per-master address
// phase buffering, and data-phase ownership tracking for response routing.
module hazard5_ahbl_arbiter
  import hazard5_ahbl_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic [N_PORTS*W_ADDR-1:0]     src_haddr,
  input  logic [N_PORTS-1:0]            src_hwrite,
  input  logic [N_PORTS*W_HTRANS-1:0]   src_htrans,
  input  logic [N_PORTS*W_HSIZE-1:0]    src_hsize,
  input  logic [N_PORTS*W_HPROT-1:0]    src_hprot,
  input  logic [N_PORTS*W_DATA-1:0]     src_hwdata,
  output logic [N_PORTS-1:0]            src_hready_resp,
  output logic [N_PORTS-1:0]            src_hresp,
  output logic [N_PORTS*W_DATA-1:0]     src_hrdata,

  output logic [W_ADDR-1:0]             dst_haddr,
  output logic                          dst_hwrite,
  output logic [W_HTRANS-1:0]           dst_htrans,
  output logic [W_HSIZE-1:0]            dst_hsize,
  output logic [W_HBURST-1:0]           dst_hburst,
  output logic [W_HPROT-1:0]            dst_hprot,
  output logic                          dst_hmastlock,
  output logic [W_DATA-1:0]             dst_hwdata,
  input  logic                          dst_hready,
  input  logic                          dst_hresp,
  input  logic [W_DATA-1:0]             dst_hrdata
);

  localparam int W_PTR = $clog2(N_PORTS);

  logic [W_ADDR-1:0]   live_addr  [N_PORTS];
  logic [W_HTRANS-1:0] live_trans [N_PORTS];
  logic [W_HSIZE-1:0]  live_size  [N_PORTS];
  logic [W_HPROT-1:0]  live_prot  [N_PORTS];
  logic [W_DATA-1:0]   live_wdata [N_PORTS];

  logic [N_PORTS-1:0]  buf_vld_q;
  logic [W_ADDR-1:0]   buf_addr_q  [N_PORTS];
  logic                buf_write_q [N_PORTS];
  logic [W_HTRANS-1:0] buf_trans_q [N_PORTS];
  logic [W_HSIZE-1:0]  buf_size_q  [N_PORTS];
  logic [W_HPROT-1:0]  buf_prot_q  [N_PORTS];

  logic [W_PTR-1:0]    ptr_q;
  logic                dph_vld_q;
  logic [W_PTR-1:0]    dph_idx_q;
  logic                hold_q;
  logic [N_PORTS-1:0]  gnt_q;

  logic [N_PORTS-1:0]  accept;
  logic [N_PORTS-1:0]  req;
  logic [N_PORTS-1:0]  rr_gnt;
  logic [N_PORTS-1:0]  gnt;
  logic                gnt_any;
  logic [W_PTR-1:0]    gnt_idx;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      live_addr[i]  = src_haddr[i*W_ADDR +: W_ADDR];
      live_trans[i] = src_htrans[i*W_HTRANS +: W_HTRANS];
      live_size[i]  = src_hsize[i*W_HSIZE +: W_HSIZE];
      live_prot[i]  = src_hprot[i*W_HPROT +: W_HPROT];
      live_wdata[i] = src_hwdata[i*W_DATA +: W_DATA];
    end
  end

  // Upstream responses depend only on registered ownership, never on the grant.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (dph_vld_q && dph_idx_q == W_PTR'(i)) begin
        src_hready_resp[i] = dst_hready;
        src_hresp[i]       = dst_hresp;
      end else begin
        src_hready_resp[i] = !buf_vld_q[i];
        src_hresp[i]       = 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      accept[i] = live_trans[i][1] && src_hready_resp[i];
    end
    req = buf_vld_q | accept;
  end

  hazard5_rr_priority #(.N(N_PORTS)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  // A stalled downstream address phase must not change, so the grant is frozen.
  assign gnt     = hold_q ? gnt_q : rr_gnt;
  assign gnt_any = |gnt;

  always_comb begin
    gnt_idx    = '0;
    dst_haddr  = '0;
    dst_hwrite = 1'b0;
    dst_htrans = HTRANS_IDLE;
    dst_hsize  = '0;
    dst_hprot  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt[i]) begin
        gnt_idx = W_PTR'(i);
        if (buf_vld_q[i]) begin
          dst_haddr  = buf_addr_q[i];
          dst_hwrite = buf_write_q[i];
          dst_htrans = buf_trans_q[i];
          dst_hsize  = buf_size_q[i];
          dst_hprot  = buf_prot_q[i];
        end else begin
          dst_haddr  = live_addr[i];
          dst_hwrite = src_hwrite[i];
          dst_htrans = live_trans[i];
          dst_hsize  = live_size[i];
          dst_hprot  = live_prot[i];
        end
      end
    end
  end

  assign dst_hburst    = HBURST_SINGLE;
  assign dst_hmastlock = 1'b0;
  assign dst_hwdata    = dph_vld_q ? live_wdata[dph_idx_q] : '0;
  assign src_hrdata    = {N_PORTS{dst_hrdata}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: buffer payloads are reset along with buf_vld_q so the downstream
      // bus never carries X even though only the valid bit is architectural.
      buf_vld_q <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        buf_addr_q[i]  <= '0;
        buf_write_q[i] <= 1'b0;
        buf_trans_q[i] <= HTRANS_IDLE;
        buf_size_q[i]  <= '0;
        buf_prot_q[i]  <= '0;
      end
      ptr_q     <= '0;
      dph_vld_q <= 1'b0;
      dph_idx_q <= '0;
      hold_q    <= 1'b0;
      gnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      hold_q <= dst_htrans[1] && !dst_hready;
      gnt_q  <= gnt;
      // A live request granted while dst stalls is captured too: the master
      // moves on once its own aphase is accepted.
      for (int i = 0; i < N_PORTS; i++) begin
        if (gnt[i] && dst_hready) begin
          buf_vld_q[i] <= 1'b0;
        end else if (accept[i]) begin
          buf_vld_q[i]   <= 1'b1;
          buf_addr_q[i]  <= live_addr[i];
          buf_write_q[i] <= src_hwrite[i];
          buf_trans_q[i] <= live_trans[i];
          buf_size_q[i]  <= live_size[i];
          buf_prot_q[i]  <= live_prot[i];
        end
      end
      if (dst_hready) begin
        dph_vld_q <= gnt_any;
        dph_idx_q <= gnt_idx;
        if (gnt_any) begin
          ptr_q <= (gnt_idx == W_PTR'(N_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard5_ahbl_arbiter.sv
// Directed bench for hazard5_ahbl_arbiter with two masters: inputs change
// 1 ns after each rising edge, outputs are checked 1 ns later.
module tb_hazard5_ahbl_arbiter;

  localparam int NP = 2;
  localparam int WA = 32;
  localparam int WD = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*WA-1:0]  src_haddr;
  logic [NP-1:0]     src_hwrite;
  logic [NP*2-1:0]   src_htrans;
  logic [NP*3-1:0]   src_hsize;
  logic [NP*4-1:0]   src_hprot;
  logic [NP*WD-1:0]  src_hwdata;
  logic [NP-1:0]     src_hready_resp;
  logic [NP-1:0]     src_hresp;
  logic [NP*WD-1:0]  src_hrdata;
  logic [WA-1:0]     dst_haddr;
  logic              dst_hwrite;
  logic [1:0]        dst_htrans;
  logic [2:0]        dst_hsize;
  logic [2:0]        dst_hburst;
  logic [3:0]        dst_hprot;
  logic              dst_hmastlock;
  logic [WD-1:0]     dst_hwdata;
  logic              dst_hready;
  logic              dst_hresp;
  logic [WD-1:0]     dst_hrdata;

  int n_tests = 0;
  int n_fail  = 0;

  hazard5_ahbl_arbiter #(.N_PORTS(NP), .W_ADDR(WA), .W_DATA(WD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .src_haddr       (src_haddr),
    .src_hwrite      (src_hwrite),
    .src_htrans      (src_htrans),
    .src_hsize       (src_hsize),
    .src_hprot       (src_hprot),
    .src_hwdata      (src_hwdata),
    .src_hready_resp (src_hready_resp),
    .src_hresp       (src_hresp),
    .src_hrdata      (src_hrdata),
    .dst_haddr       (dst_haddr),
    .dst_hwrite      (dst_hwrite),
    .dst_htrans      (dst_htrans),
    .dst_hsize       (dst_hsize),
    .dst_hburst      (dst_hburst),
    .dst_hprot       (dst_hprot),
    .dst_hmastlock   (dst_hmastlock),
    .dst_hwdata      (dst_hwdata),
    .dst_hready      (dst_hready),
    .dst_hresp       (dst_hresp),
    .dst_hrdata      (dst_hrdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic [1:0] trans, input logic [31:0] addr,
                       input logic wr);
    src_htrans[p*2 +: 2] = trans;
    src_haddr[p*WA +: WA] = addr;
    src_hwrite[p]         = wr;
  endtask

  // Advance to 1 ns after the next rising edge; callers then set inputs and #1.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dst(input string tag, input logic [1:0] trans, input logic [31:0] addr);
    check({tag, "_htrans"}, 64'(dst_htrans), 64'(trans));
    check({tag, "_haddr"},  64'(dst_haddr),  64'(addr));
  endtask

  initial begin
    rst_n      = 1'b0;
    src_haddr  = '0;
    src_hwrite = '0;
    src_htrans = '0;
    src_hsize  = {3'd2, 3'd2};
    src_hprot  = {4'h3, 4'h3};
    src_hwdata = {32'h2222_2222, 32'h1111_1111};
    dst_hready = 1'b1;
    dst_hresp  = 1'b0;
    dst_hrdata = '0;
    #12;
    chk_dst("rst", 2'b00, 32'h0);
    check("rst_hready_resp", 64'(src_hready_resp), 64'h3);
    check("rst_hresp", 64'(src_hresp), 64'h0);
    check("rst_hburst", 64'(dst_hburst), 64'h0);
    check("rst_hmastlock", 64'(dst_hmastlock), 64'h0);
    check("rst_hwrite", 64'(dst_hwrite), 64'h0);
    cyc();
    rst_n = 1'b1;

    // Single live read from port 0 goes straight through.
    cyc(); drive(0, 2'b10, 32'h100, 1'b0); #1;
    chk_dst("t1_a", 2'b10, 32'h100);
    check("t1_hsize", 64'(dst_hsize), 64'h2);
    check("t1_hprot", 64'(dst_hprot), 64'h3);
    check("t1_ready_a", 64'(src_hready_resp), 64'h3);
    cyc(); drive(0, 2'b00, 32'h0, 1'b0); dst_hrdata = 32'hCAFE_0001; #1;
    check("t1_rdata0", 64'(src_hrdata[31:0]), 64'hCAFE_0001);
    check("t1_rdata1", 64'(src_hrdata[63:32]), 64'hCAFE_0001);
    check("t1_hwdata_own0", 64'(dst_hwdata), 64'h1111_1111);
    chk_dst("t1_b", 2'b00, 32'h0);

    // Port 1 write moves the pointer back to 0 and takes data-phase ownership.
    cyc(); drive(1, 2'b10, 32'h40, 1'b1); #1;
    chk_dst("p1w", 2'b10, 32'h40);
    check("p1w_hwrite", 64'(dst_hwrite), 64'h1);
    cyc(); drive(1, 2'b00, 32'h0, 1'b0); #1;
    check("p1w_hwdata_own1", 64'(dst_hwdata), 64'h2222_2222);

    // Simultaneous requests with pointer 0: port 0 first, port 1 buffered.
    cyc(); drive(0, 2'b10, 32'h100, 1'b0); drive(1, 2'b10, 32'h200, 1'b0); #1;
    chk_dst("t2_a", 2'b10, 32'h100);
    check("t2_ready_a", 64'(src_hready_resp), 64'h3);
    cyc(); drive(0, 2'b00, 32'h0, 1'b0); drive(1, 2'b00, 32'h0, 1'b0); #1;
    chk_dst("t2_b", 2'b10, 32'h200);
    check("t2_ready_b", 64'(src_hready_resp), 64'h1);
    cyc(); #1;
    chk_dst("t2_c", 2'b00, 32'h0);
    check("t2_ready_c", 64'(src_hready_resp), 64'h3);

    // Both masters streaming: issue order alternates 0,1,0,1,0.
    cyc(); drive(0, 2'b10, 32'h300, 1'b0); drive(1, 2'b10, 32'h400, 1'b0); #1;
    chk_dst("t3_c0", 2'b10, 32'h300);
    cyc(); drive(0, 2'b10, 32'h304, 1'b0); #1;
    chk_dst("t3_c1", 2'b10, 32'h400);
    check("t3_ready_c1", 64'(src_hready_resp), 64'h1);
    cyc(); drive(1, 2'b10, 32'h404, 1'b0); #1;
    chk_dst("t3_c2", 2'b10, 32'h304);
    check("t3_ready_c2", 64'(src_hready_resp), 64'h2);
    cyc(); drive(0, 2'b10, 32'h308, 1'b0); #1;
    chk_dst("t3_c3", 2'b10, 32'h404);
    check("t3_ready_c3", 64'(src_hready_resp), 64'h1);
    cyc(); drive(0, 2'b00, 32'h0, 1'b0); drive(1, 2'b00, 32'h0, 1'b0); #1;
    chk_dst("t3_c4", 2'b10, 32'h308);
    check("t3_ready_c4", 64'(src_hready_resp), 64'h2);
    cyc(); #1;
    chk_dst("t3_c5", 2'b00, 32'h0);
    check("t3_ready_c5", 64'(src_hready_resp), 64'h3);

    // Downstream stall during port 1's aphase: grant and aphase held.
    cyc(); drive(1, 2'b10, 32'h500, 1'b1); dst_hready = 1'b0; #1;
    chk_dst("t4_d0", 2'b10, 32'h500);
    check("t4_ready_d0", 64'(src_hready_resp), 64'h3);
    cyc(); drive(1, 2'b00, 32'h0, 1'b0); drive(0, 2'b10, 32'h600, 1'b0); #1;
    chk_dst("t4_d1", 2'b10, 32'h500);
    check("t4_hwrite_d1", 64'(dst_hwrite), 64'h1);
    check("t4_ready_d1", 64'(src_hready_resp), 64'h1);
    cyc(); drive(0, 2'b00, 32'h0, 1'b0); #1;
    chk_dst("t4_d2", 2'b10, 32'h500);
    check("t4_ready_d2", 64'(src_hready_resp), 64'h0);
    cyc(); dst_hready = 1'b1; #1;
    chk_dst("t4_d3", 2'b10, 32'h500);
    cyc(); #1;
    chk_dst("t4_d4", 2'b10, 32'h600);
    check("t4_ready_d4", 64'(src_hready_resp), 64'h2);
    cyc(); #1;
    chk_dst("t4_d5", 2'b00, 32'h0);
    check("t4_ready_d5", 64'(src_hready_resp), 64'h3);

    // Two-cycle error response while port 1 owns the data phase.
    cyc(); drive(1, 2'b10, 32'h700, 1'b0); #1;
    chk_dst("t5_e0", 2'b10, 32'h700);
    cyc(); drive(1, 2'b00, 32'h0, 1'b0); dst_hready = 1'b0; dst_hresp = 1'b1; #1;
    check("t5_hresp_e1", 64'(src_hresp), 64'h2);
    check("t5_ready_e1", 64'(src_hready_resp), 64'h1);
    cyc(); dst_hready = 1'b1; #1;
    check("t5_hresp_e2", 64'(src_hresp), 64'h2);
    check("t5_ready_e2", 64'(src_hready_resp), 64'h3);
    cyc(); dst_hresp = 1'b0; #1;
    check("t5_hresp_e3", 64'(src_hresp), 64'h0);

    // Reset while port 1 holds a buffered request.
    cyc(); drive(0, 2'b10, 32'h800, 1'b0); drive(1, 2'b10, 32'h900, 1'b0); #1;
    chk_dst("t6_f0", 2'b10, 32'h800);
    cyc(); drive(0, 2'b00, 32'h0, 1'b0); drive(1, 2'b00, 32'h0, 1'b0); #1;
    check("t6_buffered", 64'(src_hready_resp), 64'h1);
    rst_n = 1'b0; #1;
    chk_dst("t6_rst", 2'b00, 32'h0);
    check("t6_ready_rst", 64'(src_hready_resp), 64'h3);
    cyc(); rst_n = 1'b1;
    cyc(); #1;
    chk_dst("t6_after", 2'b00, 32'h0);
    check("t6_ready_after", 64'(src_hready_resp), 64'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
